// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings plus the write-buffer entry layout and phase type.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_128   = 3'b100
  } hsize_t;

  localparam int WBUF_ADDR_W = 32;
  localparam int WBUF_DATA_W = 128;

  typedef struct packed {
    logic [WBUF_ADDR_W-1:0] addr;
    logic [2:0]             size;
    logic [WBUF_DATA_W-1:0] data;
  } wbuf_entry_t;

  // PH_DATA means an accepted write address is waiting for its data phase
  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_DATA = 1'b1
  } wbuf_phase_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Generic circular FIFO with wrap-bit pointers; storage is cleared on reset.
module wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          push,
  input  logic          pop,
  input  logic [WIDTH-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             pop_en;
  logic             push_en;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign pop_en  = pop & ~empty;
  // A push while full is only legal when the head leaves in the same cycle
  assign push_en = push & (~full | pop_en);
  assign count   = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_en) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (pop_en) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_slave_write_buffer.sv
// Queues AHB-Lite write transfers for the core, stalling the bus when full.
// Optional WRITE_BUF_STATS_EN adds a saturating stall_cnt output.
module ahb_slave_write_buffer
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELx,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] SWDATA,
  input  logic              size_err,
  output logic              ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_size,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_pop,
  output logic [CW-1:0]     count
`ifdef WRITE_BUF_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int EW = ADDR_W + 3 + DATA_W;

  wbuf_phase_t       phase;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic              accept;
  logic              push;
  logic              stall;
  logic              full;
  logic              empty;
  logic [EW-1:0]     head;

  assign accept = HSELx & HREADY & HWRITE &
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign push   = (phase == PH_DATA) & ~size_err & (~full | wr_pop);
  assign stall  = (phase == PH_DATA) & ~size_err & full & ~wr_pop;
  assign ready  = ~stall;

  // A stalled data phase keeps its address latched until the entry fits
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      phase  <= PH_IDLE;
      addr_q <= '0;
      size_q <= '0;
    end else if (!stall) begin
      if (accept) begin
        phase  <= PH_DATA;
        addr_q <= HADDR[ADDR_W-1:0];
        size_q <= HSIZE;
      end else begin
        phase  <= PH_IDLE;
      end
    end
  end

  wbuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push),
    .pop     (wr_pop),
    .din     ({addr_q, size_q, SWDATA}),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head)
  );

  assign wr_valid = ~empty;
  assign {wr_addr, wr_size, wr_data} = head;

`ifdef WRITE_BUF_STATS_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_slave_write_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_ahb_slave_write_buffer;

  localparam int DEPTH = 4;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic         HCLK;
  logic         HRESETn;
  logic         HSELx;
  logic [31:0]  HADDR;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [1:0]   HTRANS;
  logic         HREADY;
  logic [127:0] SWDATA;
  logic         size_err;
  logic         ready;
  logic         wr_valid;
  logic [31:0]  wr_addr;
  logic [2:0]   wr_size;
  logic [127:0] wr_data;
  logic         wr_pop;
  logic [2:0]   count;
`ifdef WRITE_BUF_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  ahb_slave_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(128)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSELx    (HSELx),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .SWDATA   (SWDATA),
    .size_err (size_err),
    .ready    (ready),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_size  (wr_size),
    .wr_data  (wr_data),
    .wr_pop   (wr_pop),
    .count    (count)
`ifdef WRITE_BUF_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0]  addr;
    logic [2:0]   size;
    logic [127:0] data;
  } entry_t;

  entry_t      q[$];
  bit          mPend;
  logic [31:0] mAddr;
  logic [2:0]  mSize;
  int          mStall;
  int          total;
  int          passed;
  logic        lastReady;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // The bus is stalled only when a good data phase meets a full queue with no pop
  function automatic bit modelReady();
    return !(mPend && !size_err && (q.size() == DEPTH) && !wr_pop);
  endfunction

  task automatic modelClear();
    q.delete();
    mPend  = 1'b0;
    mAddr  = '0;
    mSize  = '0;
    mStall = 0;
  endtask

  task automatic modelStep();
    bit isFull, stl, psh, acc;
    isFull = (q.size() == DEPTH);
    stl    = mPend && !size_err && isFull && !wr_pop;
    psh    = mPend && !size_err && (!isFull || wr_pop);
    acc    = HSELx && HREADY && HTRANS[1] && HWRITE;
    if (stl && mStall < 65535) mStall++;
    if (wr_pop && q.size() > 0) void'(q.pop_front());
    if (psh) q.push_back('{mAddr, mSize, SWDATA});
    if (!stl) begin
      mPend = acc;
      if (acc) begin
        mAddr = HADDR;
        mSize = HSIZE;
      end
    end
  endtask

  task automatic checkOutput();
    cmp("ready", ready, modelReady());
    cmp("wr_valid", wr_valid, q.size() != 0);
    cmp("count", count, q.size());
    if (q.size() > 0) begin
      cmp("wr_addr", wr_addr, q[0].addr);
      cmp("wr_size", wr_size, q[0].size);
      cmp("wr_data", wr_data, q[0].data);
    end
`ifdef WRITE_BUF_STATS_EN
    cmp("stall_cnt", stall_cnt, mStall);
`endif
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [31:0] addr, input logic [2:0] sz,
                               input logic [127:0] dat, input logic err, input logic pop);
    @(negedge HCLK);
    HSELx    = sel;
    HTRANS   = trans;
    HWRITE   = wr;
    HADDR    = addr;
    HSIZE    = sz;
    SWDATA   = dat;
    size_err = err;
    wr_pop   = pop;
    HREADY   = modelReady();
    #1;
    checkOutput();
    lastReady = ready;
    @(posedge HCLK);
    modelStep();
  endtask

  task automatic idleInputs();
    HSELx = 0; HTRANS = T_IDLE; HWRITE = 0; HADDR = '0; HSIZE = '0;
    SWDATA = '0; size_err = 0; wr_pop = 0; HREADY = 1;
  endtask

  task automatic resetDut();
    @(negedge HCLK);
    idleInputs();
    HRESETn = 1'b0;
    modelClear();
    #2;
    HRESETn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    passed = 0;
    modelClear();
    idleInputs();
    HRESETn = 1'b0;
    #12;
    cmp("rst_ready", ready, 1'b1);
    cmp("rst_wr_valid", wr_valid, 1'b0);
    cmp("rst_count", count, 0);
    cmp("rst_wr_addr", wr_addr, 0);
    cmp("rst_wr_size", wr_size, 0);
    cmp("rst_wr_data", wr_data, 0);
`ifdef WRITE_BUF_STATS_EN
    cmp("rst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single write
    applyStimulus(1, T_NONSEQ, 1, 32'h0000_0010, 3'b010, '0, 0, 0);
    applyStimulus(0, T_IDLE, 0, '0, '0, 128'hDEADBEEF, 0, 0);
    #1;
    cmp("single_valid", wr_valid, 1'b1);
    cmp("single_addr", wr_addr, 32'h10);
    cmp("single_data", wr_data, 128'hDEADBEEF);
    cmp("single_count", count, 1);
    resetDut();

    // DEPTH+1 back-to-back writes, then one pop releases the stall
    for (int i = 0; i < 5; i++)
      applyStimulus(1, (i == 0) ? T_NONSEQ : T_SEQ, 1, 32'h100 + 32'(i * 4), 3'b010,
                    128'hA0 + 128'(i) - 128'd1, 0, 0);
    #1;
    cmp("b2b_count_full", count, 4);
    applyStimulus(0, T_IDLE, 0, '0, '0, 128'hA4, 0, 0);
    cmp("b2b_stall_ready", lastReady, 1'b0);
    applyStimulus(0, T_IDLE, 0, '0, '0, 128'hA4, 0, 1);
    cmp("b2b_release_ready", lastReady, 1'b1);
    #1;
    cmp("b2b_count_after_pop", count, 4);
    cmp("b2b_head_after_pop", wr_addr, 32'h104);
`ifdef WRITE_BUF_STATS_EN
    cmp("b2b_stall_cnt", stall_cnt, 1);
`endif

    // Reset while a stalled write is pending on a full queue
    applyStimulus(1, T_NONSEQ, 1, 32'h200, 3'b010, '0, 0, 0);
    applyStimulus(0, T_IDLE, 0, '0, '0, 128'hBB, 0, 0);
    cmp("stall2_ready", lastReady, 1'b0);
    #2;
    HRESETn = 1'b0;
    modelClear();
    #1;
    cmp("midrst_count", count, 0);
    cmp("midrst_valid", wr_valid, 1'b0);
    cmp("midrst_ready", ready, 1'b1);
`ifdef WRITE_BUF_STATS_EN
    cmp("midrst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge HCLK);
    idleInputs();
    HRESETn = 1'b1;

    // Size error drops the entry; the pipelined next write is kept
    applyStimulus(1, T_NONSEQ, 1, 32'h300, 3'b001, '0, 0, 0);
    applyStimulus(1, T_NONSEQ, 1, 32'h304, 3'b010, 128'h11, 1, 0);
    applyStimulus(0, T_IDLE, 0, '0, '0, 128'h55, 0, 0);
    #1;
    cmp("szerr_count", count, 1);
    cmp("szerr_addr", wr_addr, 32'h304);
    cmp("szerr_data", wr_data, 128'h55);
    resetDut();

    // Fill, then 10 simultaneous push/pop pairs across the pointer wrap
    for (int i = 0; i < 15; i++)
      applyStimulus(i < 14, T_SEQ, 1, 32'h400 + 32'(i * 4), 3'b100,
                    {$urandom, $urandom, $urandom, $urandom}, 0, i >= 5);
    #1;
    cmp("wrap_count", count, 4);
    cmp("wrap_head", wr_addr, 32'h428);
    resetDut();

    // Random interleaving of writes, reads, IDLE/BUSY, errors and pops
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 2) != 0, $urandom, 3'($urandom_range(0, 4)),
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
